// File: rtl/wfg_wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin on ties, grant held for the whole bus cycle, one-cycle
// arbitration latency, combinational pass-through while granted, per-access watchdog raising err.
module wfg_wb_arbiter #(
  parameter int BUSW    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [BUSW-1:0] m0_adr_i,
  input  logic [BUSW-1:0] m0_dat_i,
  output logic [BUSW-1:0] m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [BUSW-1:0] m1_adr_i,
  input  logic [BUSW-1:0] m1_dat_i,
  output logic [BUSW-1:0] m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [BUSW-1:0] s_adr_o,
  output logic [BUSW-1:0] s_dat_o,
  input  logic [BUSW-1:0] s_dat_i,
  input  logic            s_ack_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;    // 1: m1 was served last
  logic [7:0] cnt_q, cnt_d;
  logic       gnt0, gnt1, sel_stb, timeout;

  // Grants are masked by reset so outputs are quiet in the reset cycle itself.
  always_comb begin
    gnt0    = (state_q == GNT0) && !wb_rst_i;
    gnt1    = (state_q == GNT1) && !wb_rst_i;
    sel_stb = (gnt0 && m0_stb_i) || (gnt1 && m1_stb_i);
    timeout = sel_stb && !s_ack_i && (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = 8'd0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0:    if (!m0_cyc_i) state_d = IDLE;
      GNT1:    if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (sel_stb && !s_ack_i && !timeout)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    s_cyc_o  = (gnt0 && m0_cyc_i) || (gnt1 && m1_cyc_i);
    s_stb_o  = sel_stb && !timeout;
    s_we_o   = (gnt0 && m0_we_i) || (gnt1 && m1_we_i);
    s_adr_o  = gnt0 ? m0_adr_i : (gnt1 ? m1_adr_i : '0);
    s_dat_o  = gnt0 ? m0_dat_i : (gnt1 ? m1_dat_i : '0);
    m0_dat_o = gnt0 ? s_dat_i : '0;
    m1_dat_o = gnt1 ? s_dat_i : '0;
    m0_ack_o = gnt0 && s_ack_i;
    m1_ack_o = gnt1 && s_ack_i;
    m0_err_o = gnt0 && timeout;
    m1_err_o = gnt1 && timeout;
  end

endmodule

// File: tb/tb_wfg_wb_arbiter.sv
// Vector table plus generated timeout sequences; expected outputs queued per cycle, checked at negedge.
module tb_wfg_wb_arbiter;
  localparam int BUSW = 32;
  localparam logic [BUSW-1:0] A0 = 32'h0000_0020, D0 = 32'h0000_0005;
  localparam logic [BUSW-1:0] A1 = 32'h1234_0040, D1 = 32'h0000_CAFE;

  logic clk = 1'b0;
  logic rst, c0, s0, c1, s1, ack;
  logic [BUSW-1:0] sdat;
  logic [BUSW-1:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o;

  always #5 clk = ~clk;

  wfg_wb_arbiter #(.BUSW(BUSW), .TIMEOUT(15)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(c0), .m0_stb_i(s0), .m0_we_i(1'b1), .m0_adr_i(A0), .m0_dat_i(D0),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(c1), .m1_stb_i(s1), .m1_we_i(1'b0), .m1_adr_i(A1), .m1_dat_i(D1),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(sdat), .s_ack_i(ack)
  );

  typedef struct packed {
    logic s_cyc, s_stb, s_we;
    logic [BUSW-1:0] s_adr, s_dat, m0_dat;
    logic m0_ack, m0_err;
    logic [BUSW-1:0] m1_dat;
    logic m1_ack, m1_err;
  } out_t;

  // gnt: 0 none, 1 master0, 2 master1; err applies to the granted master
  typedef struct {
    logic rst, c0, s0, c1, s1, ack;
    logic [1:0] gnt;
    logic err;
  } vec_t;

  typedef struct {
    int   idx;
    out_t o;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, step_no = 0;

  task automatic v(input logic r, a0, b0, a1, b1, k, input logic [1:0] g, input logic e);
    vec_t x;
    x.rst = r; x.c0 = a0; x.s0 = b0; x.c1 = a1; x.s1 = b1; x.ack = k; x.gnt = g; x.err = e;
    tbl.push_back(x);
  endtask

  task automatic step(input vec_t x);
    exp_t e;
    rst = x.rst; c0 = x.c0; s0 = x.s0; c1 = x.c1; s1 = x.s1; ack = x.ack;
    sdat = 32'h5A00_0000 | 32'(step_no);
    e.idx = step_no;
    e.o   = '0;
    if (x.gnt == 2'd1) begin
      e.o.s_cyc = x.c0; e.o.s_stb = x.s0 & ~x.err; e.o.s_we = 1'b1;
      e.o.s_adr = A0; e.o.s_dat = D0; e.o.m0_dat = sdat;
      e.o.m0_ack = x.ack; e.o.m0_err = x.err;
    end else if (x.gnt == 2'd2) begin
      e.o.s_cyc = x.c1; e.o.s_stb = x.s1 & ~x.err; e.o.s_we = 1'b0;
      e.o.s_adr = A1; e.o.s_dat = D1; e.o.m1_dat = sdat;
      e.o.m1_ack = x.ack; e.o.m1_err = x.err;
    end
    exp_q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic s(input logic a0, b0, a1, b1, k, input logic [1:0] g, input logic e);
    vec_t x;
    x.rst = 1'b0; x.c0 = a0; x.s0 = b0; x.c1 = a1; x.s1 = b1; x.ack = k; x.gnt = g; x.err = e;
    step(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      out_t a;
      e = exp_q.pop_front();
      a = '{s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m0_dat_o, m0_ack_o, m0_err_o,
            m1_dat_o, m1_ack_o, m1_err_o};
      n_cmp++;
      if (a !== e.o) begin
        n_bad++;
        $display("FAIL step%0d outputs: got %h want %h", e.idx, a, e.o);
      end
    end
  end

  initial begin
    rst = 1'b1; c0 = 0; s0 = 0; c1 = 0; s1 = 0; ack = 0; sdat = '0;
    // single master write, ack on third stb cycle, ack in IDLE ignored
    v(1,0,0,0,0,0,0,0); v(0,0,0,0,0,0,0,0); v(0,1,1,0,0,0,0,0); v(0,1,1,0,0,0,1,0);
    v(0,1,1,0,0,0,1,0); v(0,1,1,0,0,1,1,0); v(0,0,0,0,0,0,1,0); v(0,0,0,0,0,0,0,0);
    v(0,0,0,0,0,1,0,0);
    // tie after reset -> m0, idle handover to m1, next tie -> m0
    v(1,0,0,0,0,0,0,0); v(0,1,1,1,1,0,0,0); v(0,1,1,1,1,0,1,0); v(0,0,0,1,1,0,1,0);
    v(0,0,0,1,1,0,0,0); v(0,0,0,1,1,0,2,0); v(0,0,0,0,0,0,2,0); v(0,1,1,1,1,0,0,0);
    v(0,1,1,1,1,0,1,0); v(0,0,0,1,1,0,1,0); v(0,0,0,1,1,0,0,0); v(0,0,0,1,1,0,2,0);
    // reset during GNT1, then tie grants m0
    v(1,0,0,1,1,0,0,0); v(0,1,1,1,1,0,0,0); v(0,1,1,1,1,0,1,0); v(0,0,0,0,0,0,1,0);
    v(0,0,0,0,0,0,0,0);
    // m1 waits through a 4-access m0 burst
    v(0,1,1,0,0,0,0,0); v(0,1,1,1,1,1,1,0); v(0,1,1,1,1,1,1,0); v(0,1,1,1,1,1,1,0);
    v(0,1,1,1,1,1,1,0); v(0,0,0,1,1,0,1,0); v(0,0,0,1,1,0,0,0); v(0,0,0,1,1,1,2,0);
    v(0,0,0,0,0,0,2,0); v(0,0,0,0,0,0,0,0);

    @(posedge clk);
    #1;
    foreach (tbl[i]) step(tbl[i]);

    // no ack: err on 15th stb cycle, counter restarts afterwards
    s(1,1,0,0,0,0,0);
    for (int k = 1; k <= 16; k++) s(1,1,0,0,0,1,(k == 15));
    s(0,0,0,0,0,1,0); s(0,0,0,0,0,0,0);
    // ack on the 15th cycle wins over the timeout
    s(1,1,0,0,0,0,0);
    for (int k = 1; k <= 15; k++) s(1,1,0,0,(k == 15),1,0);
    s(0,0,0,0,0,1,0); s(0,0,0,0,0,0,0);
    // m1: stb low after 10 cycles clears the watchdog
    s(0,0,1,1,0,0,0);
    for (int k = 1; k <= 10; k++) s(0,0,1,1,0,2,0);
    s(0,0,1,0,0,2,0);
    for (int k = 1; k <= 15; k++) s(0,0,1,1,0,2,(k == 15));
    s(0,0,0,0,0,2,0); s(0,0,0,0,0,0,0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: got running want finished");
    $fatal(1, "time limit");
  end

endmodule
